// File: rtl/mp_add_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer.
// Word width, FSM state encodings and opcode values.
package mp_add_seq_pkg;

  localparam int W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mp_add_seq_adder.sv
// 16-bit recursive-doubling (Kogge-Stone) adder core.
// Ports: x, y, cin in; sum, ca (carry out) out.
module mp_add_seq_adder
  import mp_add_seq_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         ca
);

  logic [W-1:0] p;
  logic [W-1:0] g0, p0;
  logic [W-1:0] g1, p1;
  logic [W-1:0] g2, p2;
  logic [W-1:0] g3, p3;
  logic [W-1:0] g4;
  logic [W:0]   c;

  assign p = x ^ y;

  // cin is folded into bit 0's generate so each final
  // group generate is directly the carry out of that bit.
  always_comb begin
    g0    = x & y;
    g0[0] = (x[0] & y[0]) | (p[0] & cin);
    p0    = p;
  end

  assign g1 = g0 | (p0 & (g0 << 1));
  assign p1 = p0 & (p0 << 1);
  assign g2 = g1 | (p1 & (g1 << 2));
  assign p2 = p1 & (p1 << 2);
  assign g3 = g2 | (p2 & (g2 << 4));
  assign p3 = p2 & (p2 << 4);
  assign g4 = g3 | (p3 & (g3 << 8));

  assign c   = {g4, cin};
  assign sum = p ^ c[W-1:0];
  assign ca  = c[W];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one word per cycle, LSW first.
// Ports: start_valid/ready + op_a/op_b/sub in, res_valid/ready + result/flags out, busy.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [W*WORDS-1:0]   op_a,
  input  logic [W*WORDS-1:0]   op_b,
  input  logic                 sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W*WORDS-1:0]   result,
  output logic                 carry_out,
  output logic                 ovf,
  output logic                 zero,
  output logic                 busy
);

  localparam int N  = W * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  if (WORDS < 2 || WORDS > 16) begin : g_bad_words
    $error("mp_add_seq: WORDS must be 2..16");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          rv_q, rv_d;

  logic [W-1:0]  sum;
  logic          ca;
  logic [N-1:0]  acc_nx;

  mp_add_seq_adder u_add (
    .x   (a_q[W-1:0]),
    .y   (b_q[W-1:0]),
    .cin (c_q),
    .sum (sum),
    .ca  (ca)
  );

  assign acc_nx = {sum, acc_q[N-1:W]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    rv_d    = rv_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = (sub == OP_SUB) ? ~op_b : op_b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        acc_d = acc_nx;
        a_d   = {{W{1'b0}}, a_q[N-1:W]};
        b_d   = {{W{1'b0}}, b_q[N-1:W]};
        c_d   = ca;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Separate output register keeps the previous
          // result visible while the next one accumulates.
          res_d   = acc_nx;
          cout_d  = ca;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &
                    (sum[W-1] != a_q[W-1]);
          zero_d  = (acc_nx == '0);
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      (state_q == ST_DONE): begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      rv_q    <= rv_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = rv_q;
  assign result      = res_q;
  assign carry_out   = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4, 64-bit operands).
// Vector table + random ops against a full-width model, scoreboard queue.
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result;
  logic        carry_out;
  logic        ovf;
  logic        zero;
  logic        busy;

  mp_add_seq #(.WORDS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .ovf         (ovf),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   hs_cyc = 0;

  function automatic exp_t model(input logic [63:0] a,
                                 input logic [63:0] b,
                                 input logic s);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] full;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {64'd0, s};
    e.r    = full[63:0];
    e.c    = full[64];
    e.o    = (a[63] == bb[63]) && (full[63] != a[63]);
    e.z    = (full[63:0] == 64'd0);
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic drive_start(input logic [63:0] a,
                             input logic [63:0] b,
                             input logic s,
                             input bit push);
    int n = 0;
    @(negedge clk);
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("start_ready_wait");
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (push) sb.push_back(model(a, b, s));
    start_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input bit release_it);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      fail_now({nm, "_res_valid_wait"});
    end else begin
      chk({nm, "_latency"}, 64'(cyc - hs_cyc), 64'd4);
      if (sb.size() == 0) begin
        fail_now({nm, "_scoreboard_empty"});
      end else begin
        e = sb.pop_front();
        chk({nm, "_result"}, result, e.r);
        chk({nm, "_carry"}, 64'(carry_out), 64'(e.c));
        chk({nm, "_ovf"}, 64'(ovf), 64'(e.o));
        chk({nm, "_zero"}, 64'(zero), 64'(e.z));
      end
    end
    if (release_it) begin
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
    end
  endtask

  vec_t vt[6];
  exp_t ex;
  logic [63:0] ra, rb;

  initial begin
    vt[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{64'h5, 64'h7, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
              64'h0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({carry_out, ovf, zero}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive_start(vt[i].a, vt[i].b, vt[i].s, 1'b0);
      sb.push_back('{vt[i].r, vt[i].c, vt[i].o, vt[i].z});
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      collect($sformatf("vec%0d", i), 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 2) rb = ~ra;
      drive_start(ra, rb, 1'(i & 1), 1'b1);
      collect($sformatf("rnd%0d", i), 1'b1);
    end

    // Backpressure while a new start is pending.
    drive_start(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0, 1'b1);
    ex = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 1'b0);
    collect("bp_first", 1'b0);
    start_valid = 1'b1;
    op_a = 64'h0000_0001_0000_FFFF;
    op_b = 64'h0000_0000_0000_0002;
    sub  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", i), result, ex.r);
      chk($sformatf("bp_hold%0d_flags", i),
          64'({carry_out, ovf, zero}), 64'({ex.c, ex.o, ex.z}));
      chk($sformatf("bp_hold%0d_start_ready", i), 64'(start_ready), 64'd0);
      chk($sformatf("bp_hold%0d_res_valid", i), 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_start_ready", 64'(start_ready), 64'd1);
    chk("bp_idle_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    sb.push_back(model(64'h0000_0001_0000_FFFF, 64'h2, 1'b1));
    start_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_busy", 64'(busy), 64'd1);
    hs_cyc = hs_cyc;
    collect("bp_second", 1'b1);

    // Reset while cnt == 2 in RUN drops the transaction.
    drive_start(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_start_ready", 64'(start_ready), 64'd1);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    drive_start(64'h1, 64'h1, 1'b0, 1'b0);
    sb.push_back('{64'h2, 1'b0, 1'b0, 1'b0});
    collect("post_rst", 1'b1);

    if (sb.size() != 0) fail_now("scoreboard_leftover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around the 16-bit recursive-doubling adder core.
- Accepts one WORDS×16-bit operand pair per transaction over a valid/ready handshake.
- Feeds the operands to a single adder instance one 16-bit word per cycle, LSW first, chaining the carry between words.
- Returns the full-width result with carry, signed-overflow and zero flags; sits between the register file / ALU front-end and the shared adder core.

Parameters:
- W, 16: word width; fixed to match the adder core; not to be overridden.
- WORDS, 4: number of words per operand (4 gives 64-bit operands); legal range 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  requester presents an operation.
- start_ready  out  1  block can accept an operation.
- op_a  in  W*WORDS  operand A, sampled on start handshake.
- op_b  in  W*WORDS  operand B, sampled on start handshake.
- sub  in  1  1 = A−B, 0 = A+B; sampled on start handshake.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- result  out  W*WORDS  sum or difference, modulo 2^(W*WORDS).
- carry_out  out  1  final carry; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  result == 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge, takes effect that edge):
  - state = IDLE; start_ready = 1.
  - res_valid, result, carry_out, ovf, zero, busy all = 0; word counter = 0.
  - Reset overrides any in-flight RUN or DONE; the transaction is dropped with no output.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready, at that edge:
    - latch op_a into shift register A.
    - latch (sub ? ~op_b : op_b) into shift register B.
    - carry register = sub; cnt = 0; go to RUN.
- RUN, one adder pass per cycle:
  - Adder inputs: x = A[W-1:0], y = B[W-1:0], cin = carry register.
  - At each edge:
    - adder sum is shifted into the top of the result register (result shifts right by W).
    - carry register <= ca; A and B shift right by W; cnt += 1.
  - When cnt == WORDS-1 at the edge:
    - capture ovf = (A_msb == B_msb) & (sum_msb != A_msb), using the final word's bit W-1 (B already inverted for subtract).
    - carry_out = ca; go to DONE.
  - start_ready = 0 in RUN; start_valid is ignored.
- DONE:
  - res_valid = 1; result, carry_out, ovf and zero are held stable.
  - zero is registered from the complete result.
  - On res_valid & res_ready: res_valid drops at that edge and state returns to IDLE.
  - A new start is accepted no earlier than the following cycle.
- Latency: start handshake at edge T gives res_valid high after edge T+WORDS, so the throughput bound is one operation per WORDS+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Arithmetic wraps modulo 2^(W*WORDS); carry_out and ovf report the wrap.
- Backpressure: res_ready may stay low indefinitely; result and flags must not change while waiting.
- Outputs retain the last result after leaving DONE until the next DONE overwrites them; only res_valid qualifies them.

Decomposition:
- Shared package:
  - W = 16.
  - FSM state enum {IDLE, RUN, DONE}.
  - Opcode constants OP_ADD = 0, OP_SUB = 1.
- Sub-module: exactly one instance of the existing 16-bit recursive-doubling adder core (ports x, y, cin, sum, ca). The sequencer contains no other arithmetic beyond the ~B inversion and the ovf/zero logic.
- The counter width is $clog2(WORDS) and is derived locally.

Test Plan:
- Word-boundary carry: A=0x0000_0000_0000_FFFF, B=0x1, sub=0, start at edge T:
  - res_valid after edge T+4.
  - result=0x0000_0000_0001_0000, carry_out=0, ovf=0, zero=0.
- Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0:
  - result=0, carry_out=1, zero=1, ovf=0.
- Subtract with borrow: A=0x5, B=0x7, sub=1:
  - result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, ovf=0, zero=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, sub=0:
  - result=0x8000_0000_0000_0000, ovf=1, carry_out=0.
- Backpressure and ignored start: hold res_ready=0 for 6 cycles in DONE while start_valid=1 with new operands:
  - result and flags remain constant; start_ready=0.
  - After res_ready pulses, IDLE is entered; the new operation is accepted the next cycle and completes correctly.
- Reset mid-operation: assert rst for one cycle when cnt=2 in RUN:
  - next cycle state=IDLE, start_ready=1, res_valid=0, result=0, busy=0.
  - A subsequent operation A=0x1, B=0x1 yields result=0x2.
